// File: rtl/hdmi_acr_pkg.sv
// Shared HDMI audio clock-regeneration constants, window FSM states and nominal-CTS helper.
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package hdmi_acr_pkg;

    // Width of the CTS and N fields carried in the ACR packet.
    localparam int ACR_CTS_W = 20;

    // N is always a multiple of this; N/ACR_N_DIV strobes make one window.
    localparam int ACR_N_DIV = 128;

    // Standard HDMI N values for the common audio sample rates.
    localparam int ACR_N_32K  = 4096;
    localparam int ACR_N_44K1 = 6272;
    localparam int ACR_N_48K  = 6144;
    localparam int ACR_N_96K  = 12288;
    localparam int ACR_N_192K = 24576;

    // Window measurement state.
    typedef enum logic {
        WIN_IDLE    = 1'b0,
        WIN_MEASURE = 1'b1
    } win_state_t;

    // CTS expected for an ideal strobe stream: CLKRATE*N/(128*SAMPLERATE).
    // 64-bit arithmetic because CLKRATE*N overflows 32 bits for real clock rates.
    function automatic longint acr_nominal(input longint clkrate,
                                           input longint samplerate,
                                           input longint n_val);
        return (clkrate * n_val) / (longint'(ACR_N_DIV) * samplerate);
    endfunction

endpackage

// File: rtl/hdmi_acr_window.sv
// Counts clk cycles across S consecutive audio strobes and flags window close or timeout.
// Latency: o_close/o_count are combinational in the closing-strobe cycle; state updates 1 clk later.
// Backpressure: none; every strobe is consumed, a strobe in the timeout cycle is dropped.
module hdmi_acr_window
    import hdmi_acr_pkg::*;
#(
    parameter int CTS_W = ACR_CTS_W,
    parameter int S     = ACR_N_192K / ACR_N_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stb,
    output logic             o_close,
    output logic             o_timeout,
    output logic [CTS_W-1:0] o_count
);

    // A single-strobe window still needs a 1-bit strobe counter.
    localparam int SC_W = (S > 1) ? $clog2(S) : 1;

    localparam logic [SC_W-1:0]  S_LAST  = SC_W'(S - 1);
    localparam logic [CTS_W-1:0] CNT_MAX = {CTS_W{1'b1}};
    localparam logic [CTS_W-1:0] CNT_ONE = CTS_W'(1);

    win_state_t       r_state;
    win_state_t       w_state_nxt;
    logic [CTS_W-1:0] r_cnt;
    logic [CTS_W-1:0] w_cnt_nxt;
    logic [SC_W-1:0]  r_scnt;
    logic [SC_W-1:0]  w_scnt_nxt;
    logic             w_close;
    logic             w_timeout;

    // State, cycle counter and strobe counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WIN_IDLE;
            r_cnt   <= '0;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end

    // Next-state logic: open on first strobe, count cycles, close after S-1 further
    // strobes; saturation of the cycle counter takes priority over any strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_scnt_nxt  = r_scnt;
        w_close     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            WIN_IDLE: begin
                w_cnt_nxt  = '0;
                w_scnt_nxt = '0;
                if (i_stb) begin
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = WIN_MEASURE;
                end
            end
            WIN_MEASURE: begin
                if (r_cnt == CNT_MAX) begin
                    // Strobe stream lost: drop back and wait for a fresh opener.
                    w_timeout   = 1'b1;
                    w_state_nxt = WIN_IDLE;
                    w_cnt_nxt   = '0;
                    w_scnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (i_stb) begin
                        if (r_scnt == S_LAST) begin
                            // Closing strobe also opens the next window with no gap.
                            w_close    = 1'b1;
                            w_cnt_nxt  = CNT_ONE;
                            w_scnt_nxt = '0;
                        end else begin
                            w_scnt_nxt = r_scnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = WIN_IDLE;
                w_cnt_nxt   = '0;
                w_scnt_nxt  = '0;
            end
        endcase
    end

    assign o_close   = w_close;
    assign o_timeout = w_timeout;
    assign o_count   = r_cnt;

endmodule

// File: rtl/hdmi_acr_cts.sv
// Measures HDMI ACR CTS over N/128 audio strobes and offers it with constant N to the packet scheduler.
// Latency: cts/cts_valid update 1 clk after the closing strobe; ack clears cts_valid 1 clk later.
// Backpressure: none upstream; an unconsumed cts is overwritten by a newer capture and overrun pulses.
module hdmi_acr_cts
    import hdmi_acr_pkg::*;
#(
    parameter int N          = ACR_N_192K,
    parameter int CLKRATE    = 28000000,
    parameter int SAMPLERATE = 192000,
    parameter int CTS_W      = ACR_CTS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             audio_stb,
    output logic [CTS_W-1:0] cts,
    output logic [CTS_W-1:0] n,
    output logic             cts_valid,
    input  logic             cts_ack,
    output logic             locked,
    output logic             overrun
);

    localparam int S = N / ACR_N_DIV;

    // Value presented before the first measurement so the scheduler never sees zero.
    localparam logic [CTS_W-1:0] NOMINAL =
        CTS_W'(acr_nominal(longint'(CLKRATE), longint'(SAMPLERATE), longint'(N)));

    logic             w_close;
    logic             w_timeout;
    logic [CTS_W-1:0] w_count;

    logic [CTS_W-1:0] r_cts;
    logic             r_cts_valid;
    logic             r_locked;
    logic             r_overrun;

    hdmi_acr_window #(
        .CTS_W (CTS_W),
        .S     (S)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .i_stb     (audio_stb),
        .o_close   (w_close),
        .o_timeout (w_timeout),
        .o_count   (w_count)
    );

    // Capture register and valid/ack handshake; a capture always wins over an ack
    // so a fresh value is never lost, and overrun marks a value nobody consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cts       <= NOMINAL;
            r_cts_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_close) begin
                r_cts       <= w_count;
                r_cts_valid <= 1'b1;
                r_overrun   <= r_cts_valid & ~cts_ack;
            end else if (r_cts_valid && cts_ack) begin
                r_cts_valid <= 1'b0;
            end
        end
    end

    // Lock tracks whether the strobe stream has produced a complete window since
    // reset or the last timeout; the captured value itself survives a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_locked <= 1'b0;
        end else if (w_close) begin
            r_locked <= 1'b1;
        end else if (w_timeout) begin
            r_locked <= 1'b0;
        end
    end

    assign cts       = r_cts;
    assign n         = CTS_W'(N);
    assign cts_valid = r_cts_valid;
    assign locked    = r_locked;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_hdmi_acr_cts.sv
// Directed bench for hdmi_acr_cts with a small N and CTS_W so windows and the timeout stay short.
// Expected values: S = 1536/128 = 12, NOMINAL = 28e6*1536/(128*192000) = 1750, timeout at cnt = 2047.
// Strobe period P gives cts = 12*P (146 -> 1752, 150 -> 1800).
module tb_hdmi_acr_cts;

    localparam int TN     = 1536;
    localparam int TCTS_W = 11;
    localparam int TS     = TN / 128;

    localparam logic [TCTS_W-1:0] EXP_NOM  = 11'd1750;
    localparam logic [TCTS_W-1:0] EXP_N    = 11'd1536;
    localparam logic [TCTS_W-1:0] EXP_P146 = 11'd1752;
    localparam logic [TCTS_W-1:0] EXP_P150 = 11'd1800;

    logic              clk;
    logic              reset;
    logic              audio_stb;
    logic [TCTS_W-1:0] cts;
    logic [TCTS_W-1:0] n;
    logic              cts_valid;
    logic              cts_ack;
    logic              locked;
    logic              overrun;

    int total;
    int bad;

    // Strobe generator controls.
    bit stb_on;
    int stb_period;
    int stb_total;
    int stb_phase;

    hdmi_acr_cts #(
        .N          (TN),
        .CLKRATE    (28000000),
        .SAMPLERATE (192000),
        .CTS_W      (TCTS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .audio_stb (audio_stb),
        .cts       (cts),
        .n         (n),
        .cts_valid (cts_valid),
        .cts_ack   (cts_ack),
        .locked    (locked),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle strobe every stb_period clocks while enabled; first strobe immediately.
    initial begin
        audio_stb = 1'b0;
        stb_phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stb_on) begin
                if (stb_phase == 0) begin
                    audio_stb = 1'b1;
                    stb_total = stb_total + 1;
                end else begin
                    audio_stb = 1'b0;
                end
                stb_phase = (stb_phase + 1 >= stb_period) ? 0 : stb_phase + 1;
            end else begin
                audio_stb = 1'b0;
                stb_phase = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at the negedge inside the cycle where strobe number 'target' is driven.
    task automatic wait_stb(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (stb_total >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        stb_on  = 1'b0;
        cts_ack = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        repeat (100) @(negedge clk);
        total++; if (cts !== EXP_NOM) begin bad++; $display("FAIL reset_cts: got %0d want %0d", cts, EXP_NOM); end
        total++; if (cts_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", cts_valid); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (n !== EXP_N) begin bad++; $display("FAIL reset_n: got %0d want %0d", n, EXP_N); end
    endtask

    task automatic test_capture();
        int base;
        bit ok;
        do_reset();
        stb_period = 146;
        base = stb_total;
        stb_on = 1'b1;
        wait_stb(base + TS + 1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL cap_wait1: got timeout want strobe %0d", TS + 1); end
        total++; if (cts_valid !== 1'b0) begin bad++; $display("FAIL cap_latency: got valid=%b want 0 during closing strobe", cts_valid); end
        @(posedge clk); @(negedge clk);
        total++; if (cts !== EXP_P146) begin bad++; $display("FAIL cap_cts: got %0d want %0d", cts, EXP_P146); end
        total++; if (cts_valid !== 1'b1) begin bad++; $display("FAIL cap_valid: got %b want 1", cts_valid); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL cap_locked: got %b want 1", locked); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL cap_no_overrun: got %b want 0", overrun); end
        // Second window, no ack: overwrite with overrun pulse.
        wait_stb(base + 2 * TS + 1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL cap_wait2: got timeout want strobe %0d", 2 * TS + 1); end
        @(posedge clk); @(negedge clk);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        total++; if (cts !== EXP_P146) begin bad++; $display("FAIL ovr_cts: got %0d want %0d", cts, EXP_P146); end
        total++; if (cts_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", cts_valid); end
        @(negedge clk);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
    endtask

    task automatic test_continuous_ack();
        int ov_seen;
        bit got;
        do_reset();
        stb_period = 146;
        stb_on = 1'b1;
        ov_seen = 0;
        for (int w = 0; w < 3; w++) begin
            got = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (overrun === 1'b1) ov_seen++;
                if (cts_valid === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            total++; if (!got) begin bad++; $display("FAIL cont_wait%0d: got no valid want valid", w); end
            total++; if (cts !== EXP_P146) begin bad++; $display("FAIL cont_cts%0d: got %0d want %0d", w, cts, EXP_P146); end
            repeat (5) begin
                @(negedge clk);
                if (overrun === 1'b1) ov_seen++;
            end
            total++; if (cts_valid !== 1'b1) begin bad++; $display("FAIL cont_hold%0d: got %b want 1", w, cts_valid); end
            cts_ack = 1'b1;
            @(negedge clk);
            cts_ack = 1'b0;
            total++; if (cts_valid !== 1'b0) begin bad++; $display("FAIL cont_ack%0d: got %b want 0", w, cts_valid); end
        end
        total++; if (ov_seen != 0) begin bad++; $display("FAIL cont_overrun: got %0d pulses want 0", ov_seen); end
    endtask

    task automatic test_ack_on_capture();
        int base;
        bit ok;
        do_reset();
        stb_period = 146;
        base = stb_total;
        stb_on = 1'b1;
        wait_stb(base + TS + 1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL aoc_wait1: got timeout want strobe %0d", TS + 1); end
        // Next window runs at period 150 so the new capture is distinguishable.
        stb_period = 150;
        @(posedge clk); @(negedge clk);
        total++; if (cts !== EXP_P146 || cts_valid !== 1'b1) begin bad++; $display("FAIL aoc_first: got cts=%0d valid=%b want %0d/1", cts, cts_valid, EXP_P146); end
        wait_stb(base + 2 * TS + 1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL aoc_wait2: got timeout want strobe %0d", 2 * TS + 1); end
        cts_ack = 1'b1;
        @(posedge clk); #1;
        cts_ack = 1'b0;
        @(negedge clk);
        total++; if (cts !== EXP_P150) begin bad++; $display("FAIL aoc_cts: got %0d want %0d", cts, EXP_P150); end
        total++; if (cts_valid !== 1'b1) begin bad++; $display("FAIL aoc_valid: got %b want 1", cts_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL aoc_overrun: got %b want 0", overrun); end
        @(negedge clk);
        total++; if (cts_valid !== 1'b1) begin bad++; $display("FAIL aoc_valid_hold: got %b want 1", cts_valid); end
    endtask

    task automatic test_timeout();
        int base;
        bit ok;
        do_reset();
        stb_period = 146;
        base = stb_total;
        stb_on = 1'b1;
        wait_stb(base + TS + 1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_wait1: got timeout want strobe %0d", TS + 1); end
        // Two more strobes into window 2, then the stream stops; cnt = 2*146 = 292 now.
        wait_stb(base + TS + 3, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_wait2: got timeout want strobe %0d", TS + 3); end
        stb_on = 1'b0;
        repeat (2047 - 292) @(negedge clk);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL to_pre: got locked=%b want 1 at cnt=max", locked); end
        @(negedge clk);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_unlock: got locked=%b want 0", locked); end
        total++; if (cts !== EXP_P146) begin bad++; $display("FAIL to_cts_kept: got %0d want %0d", cts, EXP_P146); end
        total++; if (cts_valid !== 1'b1) begin bad++; $display("FAIL to_valid_kept: got %b want 1", cts_valid); end
        repeat (20) @(negedge clk);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_idle: got locked=%b want 0", locked); end
        stb_period = 150;
        base = stb_total;
        stb_on = 1'b1;
        wait_stb(base + TS + 1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_wait3: got timeout want strobe %0d", TS + 1); end
        @(posedge clk); @(negedge clk);
        total++; if (cts !== EXP_P150) begin bad++; $display("FAIL to_relock_cts: got %0d want %0d", cts, EXP_P150); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL to_relock: got %b want 1", locked); end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        do_reset();
        stb_period = 146;
        base = stb_total;
        stb_on = 1'b1;
        wait_stb(base + TS + 1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_wait1: got timeout want strobe %0d", TS + 1); end
        wait_stb(base + TS + 7, 2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_wait2: got timeout want strobe %0d", TS + 7); end
        @(posedge clk); #3;
        reset  = 1'b1;
        stb_on = 1'b0;
        #1;
        total++; if (cts !== EXP_NOM || cts_valid !== 1'b0 || locked !== 1'b0) begin
            bad++; $display("FAIL rm_async: got cts=%0d valid=%b locked=%b want %0d/0/0", cts, cts_valid, locked, EXP_NOM);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        base = stb_total;
        stb_on = 1'b1;
        wait_stb(base + TS, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_wait3: got timeout want strobe %0d", TS); end
        @(posedge clk); @(negedge clk);
        total++; if (cts_valid !== 1'b0) begin bad++; $display("FAIL rm_early: got valid=%b want 0 after %0d strobes", cts_valid, TS); end
        wait_stb(base + TS + 1, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_wait4: got timeout want strobe %0d", TS + 1); end
        @(posedge clk); @(negedge clk);
        total++; if (cts !== EXP_P146 || cts_valid !== 1'b1) begin
            bad++; $display("FAIL rm_fresh: got cts=%0d valid=%b want %0d/1", cts, cts_valid, EXP_P146);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        cts_ack    = 1'b0;
        stb_on     = 1'b0;
        stb_period = 146;
        stb_total  = 0;
        test_reset();
        test_capture();
        test_continuous_ack();
        test_ack_on_capture();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_acr_cts.md
Name: hdmi_acr_cts

Overview:
Consumer of the one-cycle audio sample-rate strobe in the HDMI audio path. Measures how many clk cycles elapse across N/128 consecutive strobes, which gives the HDMI Audio Clock Regeneration CTS value. Publishes CTS alongside the fixed N value to the ACR packet scheduler through a valid/ack handshake. Also reports whether the strobe stream is alive (locked).

Parameters:
N, 24576, HDMI ACR N value; must be a multiple of 128 (24576 for 192 kHz).
CLKRATE, 28000000, clk frequency in Hz; used only for the reset/nominal CTS.
SAMPLERATE, 192000, nominal audio rate in Hz; used only for the reset/nominal CTS.
CTS_W, 20, width of CTS and N outputs.

Ports:
clk  in  1  design clock (same domain as audio_stb)
reset  in  1  asynchronous, active-high
audio_stb  in  1  one-cycle strobe per audio sample, synchronous to clk
cts  out  CTS_W  last captured CTS value
n  out  CTS_W  constant N
cts_valid  out  1  cts holds an unconsumed measurement
cts_ack  in  1  scheduler consumed cts; honoured only while cts_valid=1
locked  out  1  at least one full window measured since reset/timeout
overrun  out  1  one-cycle pulse: measurement replaced an unconsumed one

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Constants:
  - S = N/128 strobes per window.
  - NOMINAL = CLKRATE*N/(128*SAMPLERATE), computed at elaboration; defaults give 28000.
- Reset values: cts=NOMINAL, cts_valid=0, locked=0, overrun=0, state=IDLE, cycle counter cnt=0, strobe counter scnt=0. Output n is always N.
- State IDLE:
  - cnt and scnt are held at 0.
  - The first audio_stb opens a window: cnt<=1, scnt<=0, state<=MEASURE.
- State MEASURE:
  - cnt increments by 1 every clk.
  - On audio_stb with scnt<S-1: scnt<=scnt+1.
  - On audio_stb with scnt==S-1 (window close):
    - cts<=cnt, cts_valid<=1, locked<=1.
    - cnt<=1 and scnt<=0, so the closing strobe opens the next window with no gap.
  - Result: strobes every P clocks give cts=S*P. Capture latency is 1 clk after the closing strobe.
- Timeout:
  - If cnt reaches 2^CTS_W-1 in MEASURE without a window close, the block enters IDLE, clears cnt and scnt, and sets locked<=0.
  - cts and cts_valid are unchanged by a timeout.
  - A strobe arriving in the timeout cycle is ignored.
- Handshake:
  - cts_ack=1 while cts_valid=1 clears cts_valid on the next edge.
  - cts_ack while cts_valid=0 is ignored.
  - cts is stable whenever cts_valid=1, except when it is overwritten by a capture.
- Simultaneous capture and ack: cts_valid stays 1, cts takes the new value, overrun=0.
- Capture while cts_valid=1 without ack: cts is overwritten with the newest value, cts_valid stays 1, and overrun pulses high for exactly 1 clk.
- Width rules: cnt is CTS_W bits unsigned and never wraps, because it saturates into the timeout; scnt is clog2(S) bits.
- Reset mid-window: all state returns to reset values immediately, with no partial capture.

Decomposition:
- Shared HDMI audio package holds:
  - the CTS_W constant;
  - the standard N values for 32/44.1/48/96/192 kHz;
  - a function computing NOMINAL from (CLKRATE, SAMPLERATE, N).
- Natural sub-module: hdmi_acr_window, containing cnt, scnt, the close and timeout detection, and a close pulse plus count output.
- The top level keeps the capture register, the handshake, locked and overrun.

Test Plan:
- After reset with no strobes for 100 clk: cts=28000, cts_valid=0, locked=0, overrun=0, n=24576.
- Strobes every 146 clk, 193 strobes, ack held 0:
  - After the 193rd strobe plus 1 clk: cts=28032, cts_valid=1, locked=1.
  - Next window with no ack produces the same value and overrun pulses for 1 clk.
- Continuous strobes every 146 clk, ack pulsed 5 clk after each valid rise: every capture is 28032, overrun never asserts, and cts_valid falls 1 clk after each ack.
- Ack asserted on the exact capture edge: cts_valid remains 1, cts takes the new value, overrun=0.
- Strobes stop mid-window after lock: when cnt reaches 1048575 the block times out, locked=0 and cts keeps its last value. The next strobe reopens a window, and after 193 strobes at period 150, cts=28800 and locked=1.
- Assert reset in the middle of window 2: outputs return to reset values immediately, and the next capture needs a fresh 193-strobe sequence.
